// File: rtl/tlb_ctrl.sv
// TLB array plus TLBP/TLBR/TLBWI sequencer beside CP0.
// Build option: define TLB_PARALLEL_PROBE_EN to probe every entry in a single cycle.
module tlb_ctrl #(
    parameter int TLBNUM = 16,
    parameter int IDXW   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tlb_req,
    input  logic [1:0]  tlb_op,
    input  logic        flush,
    input  logic [31:0] c0_index,
    input  logic [31:0] c0_entryhi,
    input  logic [31:0] c0_entrylo0,
    input  logic [31:0] c0_entrylo1,
    output logic        tlb_busy,
    output logic        tlb_done,
    output logic        tlbp_we,
    output logic        tlbr_we,
    output logic [31:0] index,
    output logic [31:0] entryhi,
    output logic [31:0] entrylo0,
    output logic [31:0] entrylo1
);

    // state   | meaning
    // S_IDLE  | waiting for an accepted tlb_req
    // S_PROBE | TLBP compare (one entry per cycle, or all at once)
    // S_READ  | TLBR load of result registers from entry[idx]
    // S_WRITE | TLBWI store of the snapshot into entry[idx]
    // S_RESP  | completion pulse cycle
    typedef enum logic [2:0] {S_IDLE, S_PROBE, S_READ, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] OP_P    = 2'b00;
    localparam logic [1:0] OP_R    = 2'b01;
    localparam logic [1:0] OP_RSVD = 2'b11;

    state_t            state;
    logic [1:0]        op_r;
    logic [IDXW-1:0]   snap_idx;
    logic [31:0]       snap_hi;
    logic [31:0]       snap_lo0;
    logic [31:0]       snap_lo1;

    // entry storage; lo fields keep bits [25:1] of the EntryLo image
    logic [18:0]       e_vpn2 [TLBNUM];
    logic [7:0]        e_asid [TLBNUM];
    logic              e_g    [TLBNUM];
    logic [24:0]       e_lo0  [TLBNUM];
    logic [24:0]       e_lo1  [TLBNUM];

    logic [TLBNUM-1:0] hit_vec;
    logic              wr_en;
    logic              unused_bits;

    assign unused_bits = ^{c0_index[31:IDXW], snap_hi[12:8], snap_lo0[31:26], snap_lo1[31:26]};

    always_comb begin
        hit_vec = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            hit_vec[i] = (e_vpn2[i] == snap_hi[31:13]) && (e_g[i] || (e_asid[i] == snap_hi[7:0]));
        end
    end

`ifdef TLB_PARALLEL_PROBE_EN
    logic [IDXW-1:0] first_idx;

    // scan downward so the lowest matching index is the one left standing
    always_comb begin
        first_idx = '0;
        for (int i = TLBNUM - 1; i >= 0; i--) begin
            if (hit_vec[i]) first_idx = IDXW'(i);
        end
    end
`else
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(TLBNUM - 1);
    logic [IDXW-1:0] ptr;
`endif

    assign wr_en    = (state == S_WRITE) && !flush;
    assign tlb_busy = (state != S_IDLE);
    assign tlb_done = (state == S_RESP) && !flush;
    assign tlbp_we  = tlb_done && (op_r == OP_P);
    assign tlbr_we  = tlb_done && (op_r == OP_R);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TLBNUM; i++) begin
                e_vpn2[i] <= '0;
                e_asid[i] <= '0;
                e_g[i]    <= 1'b0;
                e_lo0[i]  <= '0;
                e_lo1[i]  <= '0;
            end
        end else if (wr_en) begin
            e_vpn2[snap_idx] <= snap_hi[31:13];
            e_asid[snap_idx] <= snap_hi[7:0];
            e_g[snap_idx]    <= snap_lo0[0] & snap_lo1[0];
            e_lo0[snap_idx]  <= snap_lo0[25:1];
            e_lo1[snap_idx]  <= snap_lo1[25:1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            op_r     <= OP_P;
            snap_idx <= '0;
            snap_hi  <= '0;
            snap_lo0 <= '0;
            snap_lo1 <= '0;
`ifndef TLB_PARALLEL_PROBE_EN
            ptr      <= '0;
`endif
            index    <= '0;
            entryhi  <= '0;
            entrylo0 <= '0;
            entrylo1 <= '0;
        end else if (state == S_IDLE) begin
            if (tlb_req && tlb_op != OP_RSVD) begin
                op_r     <= tlb_op;
                snap_idx <= c0_index[IDXW-1:0];
                snap_hi  <= c0_entryhi;
                snap_lo0 <= c0_entrylo0;
                snap_lo1 <= c0_entrylo1;
`ifndef TLB_PARALLEL_PROBE_EN
                ptr      <= '0;
`endif
                case (tlb_op)
                    OP_P:    state <= S_PROBE;
                    OP_R:    state <= S_READ;
                    default: state <= S_WRITE;
                endcase
            end
        end else if (flush) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_PROBE: begin
`ifdef TLB_PARALLEL_PROBE_EN
                    index <= (|hit_vec) ? 32'(first_idx) : 32'h8000_0000;
                    state <= S_RESP;
`else
                    if (hit_vec[ptr]) begin
                        index <= 32'(ptr);
                        state <= S_RESP;
                    end else if (ptr == LAST_IDX) begin
                        index <= 32'h8000_0000;
                        state <= S_RESP;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
`endif
                end
                S_READ: begin
                    entryhi  <= {e_vpn2[snap_idx], 5'b0, e_asid[snap_idx]};
                    entrylo0 <= {6'b0, e_lo0[snap_idx], e_g[snap_idx]};
                    entrylo1 <= {6'b0, e_lo1[snap_idx], e_g[snap_idx]};
                    state    <= S_RESP;
                end
                S_WRITE: state <= S_RESP;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
